// File: rtl/bram_ctrl_if.sv
// Bus bundle between the address decoder / bram array and bram_ctrl.
// The slave modport is the controller's view. The master modport is the environment's view:
// the decoder request side and the bram array together.
interface bram_ctrl_if #(
  parameter int unsigned bram_depth = 10
) ();

  // Decoder request / response
  logic                  mem_valid;
  logic                  mem_instr;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_ready;

  // Synchronous array port
  logic                  bram_wen;
  logic [bram_depth-1:0] bram_waddr;
  logic [bram_depth-1:0] bram_raddr;
  logic [31:0]           bram_wdata;
  logic [3:0]            bram_wstrb;
  logic [31:0]           bram_rdata;

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_rdata,
    output mem_ready,
    output bram_wen,
    output bram_waddr,
    output bram_raddr,
    output bram_wdata,
    output bram_wstrb,
    input  bram_rdata
  );

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_rdata,
    input  mem_ready,
    input  bram_wen,
    input  bram_waddr,
    input  bram_raddr,
    input  bram_wdata,
    input  bram_wstrb,
    output bram_rdata
  );

endinterface

// File: rtl/bram_ctrl.sv
// bram_ctrl: turns single-cycle decoder requests into registered bram strobes.
// It can insert optional wait states and squashes out-of-range accesses.
// It returns exactly one mem_ready pulse per accepted request.
module bram_ctrl #(
  parameter int unsigned bram_depth  = 10,
  parameter int unsigned wait_states = 0
) (
  input  logic     clk,
  input  logic     rst,
  bram_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WS = CNT_W'(wait_states);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;

  // Request registers captured at accept time
  logic [bram_depth-1:0] req_word;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  req_instr;
  logic                  req_inrange;
  logic                  req_write;

  // Decode of the live request, only sampled in IDLE
  logic [bram_depth-1:0] in_word;
  logic                  in_inrange;
  logic                  in_write;
  logic [1:0]            unused_addr_lsb;

  // Byte offset within the word has no meaning for word access
  assign unused_addr_lsb = bus.mem_addr[1:0];

  // Word index, range and write qualification of the incoming request
  assign in_word    = bus.mem_addr[bram_depth+1:2];
  assign in_inrange = (bus.mem_addr[31:bram_depth+2] == '0);
  assign in_write   = (bus.mem_wstrb != 4'd0) && !bus.mem_instr;

  // A fetch never writes, even with strobes set
  assign req_write = (req_wstrb != 4'd0) && !req_instr;

  // Read data gated by state: only in-range reads expose the array output
  assign bus.mem_rdata = (state == S_RESP && req_inrange && !req_write) ? bus.bram_rdata : 32'd0;

  // Request FSM with registered bram strobes and ready pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      req_word       <= '0;
      req_wdata      <= '0;
      req_wstrb      <= '0;
      req_instr      <= 1'b0;
      req_inrange    <= 1'b0;
      bus.mem_ready  <= 1'b0;
      bus.bram_wen   <= 1'b0;
      bus.bram_waddr <= '0;
      bus.bram_raddr <= '0;
      bus.bram_wdata <= '0;
      bus.bram_wstrb <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.bram_wen  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mem_valid) begin
            req_word    <= in_word;
            req_wdata   <= bus.mem_wdata;
            req_wstrb   <= bus.mem_wstrb;
            req_instr   <= bus.mem_instr;
            req_inrange <= in_inrange;
            if (WS != '0) begin
              cnt   <= WS - CNT_W'(1);
              state <= S_WAIT;
            end else begin
              // No wait states: present the access straight from the request
              bus.bram_waddr <= in_word;
              bus.bram_raddr <= in_word;
              bus.bram_wdata <= bus.mem_wdata;
              bus.bram_wstrb <= bus.mem_wstrb;
              bus.bram_wen   <= in_write && in_inrange;
              state          <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            bus.bram_waddr <= req_word;
            bus.bram_raddr <= req_word;
            bus.bram_wdata <= req_wdata;
            bus.bram_wstrb <= req_wstrb;
            bus.bram_wen   <= req_write && req_inrange;
            state          <= S_ACCESS;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACCESS: begin
          bus.mem_ready <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bram_ctrl.md
# bram_ctrl

Slave-side controller between the SoC address decoder's BRAM port and the synchronous `bram` array. It turns the decoder's single-cycle valid/ready request into registered BRAM read/write strobes and returns exactly one `mem_ready` pulse per accepted request. It adds optional wait states and rejects out-of-range addresses. It owns the `bram_wen` and ready generation that the decoder does not produce itself.

## Interface
- `bram_depth`, default 10: word-address width; the array holds 2^bram_depth 32-bit words.
- `wait_states`, default 0: extra cycles (0..15) inserted before the BRAM access.
- `clk` in, 1: single clock; the same clock as the CPU and the decoder (`clk_pll` at SoC level).
- `rst` in, 1: reset, asynchronous and active-high.
- `mem_valid` in, 1: request strobe from the decoder, one cycle per request.
- `mem_instr` in, 1: request is an instruction fetch; it must never write.
- `mem_addr` in, 32: byte address, already rebased to 0 by the decoder.
- `mem_wdata` in, 32: write data.
- `mem_wstrb` in, 4: byte strobes; 0 means read.
- `mem_rdata` out, 32: read data, valid only while `mem_ready`=1.
- `mem_ready` out, 1: one-cycle completion pulse.
- `bram_wen` out, 1: BRAM write enable.
- `bram_waddr` out, bram_depth: BRAM write word address.
- `bram_raddr` out, bram_depth: BRAM read word address.
- `bram_wdata` out, 32: BRAM write data.
- `bram_wstrb` out, 4: BRAM byte strobes.
- `bram_rdata` in, 32: BRAM read data, registered inside `bram` with 1-cycle latency.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- **IDLE**
  - On `mem_valid`=1, latch addr, wdata, wstrb and instr into request registers.
  - Go to WAIT if `wait_states`>0, else go to ACCESS.
  - `mem_valid` in any state other than IDLE is ignored: one outstanding request, and the requestor must not issue until `mem_ready`.
- **Write qualifier**: a request is a write when latched wstrb≠0 and instr=0. A fetch with nonzero wstrb is treated as a read.
- **Range check**: an address is in range iff `addr[31:bram_depth+2]`==0. `addr[1:0]` is ignored (word access).
- **WAIT**: a 4-bit counter loads `wait_states`-1 on entry and decrements each cycle. Exit to ACCESS on the cycle the counter reads 0.
- **ACCESS**
  - Drive `bram_raddr` = `bram_waddr` = `addr[bram_depth+1:2]`, plus `bram_wdata` and `bram_wstrb` from the request registers.
  - Drive `bram_wen`=1 only for an in-range write.
  - Go to RESP.
- **RESP**
  - Drive `mem_ready`=1 for exactly one cycle.
  - `mem_rdata` = `bram_rdata` for an in-range read. It is 0 for a write or an out-of-range request.
  - Go to IDLE.
- **Out-of-range requests** follow the same path and latency, with `bram_wen` held 0. The array is never modified.
- All outputs are registered or decoded from state only. No combinational path exists from `mem_*` inputs to outputs.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `bram_wen`=0, `bram_waddr`=0, `bram_raddr`=0, `bram_wdata`=0, `bram_wstrb`=0, counter 0, request registers 0.
- Latency: `mem_valid` at cycle T gives `mem_ready` at T+2+`wait_states`. Reads and writes have the same latency.
- `bram_wen` is high for exactly one cycle per write, at cycle T+1+`wait_states`.
- Throughput: the earliest next accept is the cycle after RESP, i.e. 3+`wait_states` cycles per request.
- A `mem_valid` that coincides with RESP is ignored. The decoder guarantees it never issues then.
- Reset asserted in any state forces IDLE immediately. A pending response is dropped, and a write in ACCESS is cancelled if reset arrives before the clock edge.
- Read-after-write to the same word returns the new data, because the accesses are sequential.
- With `wait_states`=15 the counter does not wrap: exactly 15 WAIT cycles.

## Test plan
- **Write then read, `wait_states`=0**
  - Stimulus: write 0xDEADBEEF, wstrb 0xF, addr 0x10; then read addr 0x10.
  - Required: `bram_wen` pulses at T+1 with waddr 4; `mem_ready` at T+2; the read returns 0xDEADBEEF at T'+2.
- **Byte strobe**
  - Stimulus: after the write above, write 0x000000AA with wstrb 0x1 to 0x10, then read 0x10.
  - Required: the read returns 0xDEADBEAA.
- **Wait states, `wait_states`=3**
  - Stimulus: a read at T.
  - Required: `mem_ready` at exactly T+5; a `mem_valid` pulse at T+2 is ignored, giving no second ready.
- **Out of range, `bram_depth`=10**
  - Stimulus: write to 0x00001000.
  - Required: `bram_wen` stays 0; `mem_ready` at T+2 with rdata 0; a later read of 0x0 is unchanged.
- **Fetch with strobes**
  - Stimulus: `mem_instr`=1, wstrb 0xF, addr 0x10.
  - Required: no write occurs; 0xDEADBEAA is returned.
- **Reset mid-operation**
  - Stimulus: assert `rst` during WAIT or ACCESS of a write.
  - Required: outputs go to their reset values asynchronously; no `mem_ready`; the target word is unchanged; the next request completes normally.
